// File: rtl/var_unshift_if.sv
// Stream-side bundle for var_unshift: word input, field request and field result.
// The DUT connects through the slave modport, the traffic source through master.
interface var_unshift_if #(
   parameter int W  = 32,
   parameter int LW = 6,
   parameter int CW = 7
);
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic          req_valid;
   logic [LW-1:0] req_len;
   logic          req_ready;
   logic [W-1:0]  q;
   logic          q_valid;
   logic          err;
   logic [CW-1:0] count;
   logic [1:0]    occ;

   modport master (
      output in_data, in_valid, req_valid, req_len,
      input  in_ready, req_ready, q, q_valid, err, count, occ
   );

   modport slave (
      input  in_data, in_valid, req_valid, req_len,
      output in_ready, req_ready, q, q_valid, err, count, occ
   );
endinterface

// File: rtl/var_unshift.sv
// Variable-width bit unpacker: buffers W-bit words in a 2W-bit window and hands out
// right-aligned 1..W bit fields, LSB-first or MSB-first.
module var_unshift #(
   parameter int W  = 32,
   parameter int LW = 6,
   parameter int CW = 7
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            dir,
   input  logic            flush,
   var_unshift_if.slave    bus
);
   localparam int BW = 2 * W;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_HIGH    = 2'd2,
      OCC_FULL    = 2'd3
   } occ_t;

   logic [BW-1:0] data_buf;
   logic [BW-1:0] buf_pop;
   logic [BW-1:0] buf_nxt;
   logic [BW-1:0] word_ext;
   logic [BW-1:0] word_mask;
   logic [CW-1:0] count_r;
   logic [CW-1:0] cnt_pop;
   logic [CW-1:0] cnt_nxt;
   logic [CW-1:0] len_c;
   logic [CW-1:0] push_sh;
   logic [W-1:0]  q_r;
   logic [W-1:0]  field;
   logic          q_valid_r;
   logic          err_r;
   logic          dir_q;
   logic          len_legal;
   logic          push_hs;
   logic          push;
   logic          pop_ok;
   logic          pop_bad;
   occ_t          occ;

   // Handshakes: a transfer happens on a posedge where valid and ready are both high;
   // ready depends only on registered count and req_len, never on the valid inputs.
   assign len_c         = CW'(bus.req_len);
   assign len_legal     = (bus.req_len != '0) && (len_c <= CW'(W));
   assign bus.in_ready  = (count_r <= CW'(W));
   assign bus.req_ready = !len_legal || (count_r >= len_c);

   assign push_hs = bus.in_valid && bus.in_ready;
   assign push    = push_hs && !flush;
   assign pop_ok  = bus.req_valid && bus.req_ready && len_legal && !flush;
   assign pop_bad = bus.req_valid && !len_legal && !flush;

   // MSB-first fields sit at the top of the window; LSB-first fields at the bottom.
   always_comb begin
      field = '0;
      if (dir_q) field = W'(data_buf >> (CW'(BW) - len_c));
      else       field = data_buf[W-1:0] & ~({W{1'b1}} << bus.req_len);
   end

   // Pop first on the bits already held, then append the incoming word behind them.
   always_comb begin
      buf_pop = data_buf;
      cnt_pop = count_r;
      if (pop_ok) begin
         buf_pop = dir_q ? (data_buf << bus.req_len) : (data_buf >> bus.req_len);
         cnt_pop = count_r - len_c;
      end
      push_sh   = dir_q ? (CW'(W) - cnt_pop) : cnt_pop;
      word_ext  = BW'(bus.in_data) << push_sh;
      word_mask = BW'({W{1'b1}}) << push_sh;
      buf_nxt   = buf_pop;
      cnt_nxt   = cnt_pop;
      if (push) begin
         buf_nxt = (buf_pop & ~word_mask) | word_ext;
         cnt_nxt = cnt_pop + CW'(W);
      end
      if (flush) begin
         buf_nxt = '0;
         cnt_nxt = '0;
      end
   end

   always_comb begin
      occ = OCC_PARTIAL;
      if (count_r == '0)              occ = OCC_EMPTY;
      else if (count_r == CW'(BW))    occ = OCC_FULL;
      else if (count_r > CW'(W))      occ = OCC_HIGH;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         data_buf  <= '0;
         count_r   <= '0;
         q_r       <= '0;
         q_valid_r <= 1'b0;
         err_r     <= 1'b0;
         dir_q     <= 1'b0;
      end else begin
         data_buf  <= buf_nxt;
         count_r   <= cnt_nxt;
         q_valid_r <= pop_ok;
         err_r     <= pop_bad;
         if (pop_ok)       q_r <= field;
         else if (pop_bad) q_r <= '0;
         // Direction only changes while the window is empty and idle.
         if ((count_r == '0) && !push_hs) dir_q <= dir;
      end
   end

   assign bus.q       = q_r;
   assign bus.q_valid = q_valid_r;
   assign bus.err     = err_r;
   assign bus.count   = count_r;
   assign bus.occ     = occ;
endmodule

// File: tb/tb_var_unshift.sv
// Directed bench for var_unshift: hand-computed fields, occupancy, stall, error,
// reset and flush behaviour.
module tb_var_unshift;
   logic clk;
   logic clr;
   logic dir;
   logic flush;
   int   n_checks;
   int   n_errors;
   logic [31:0] exp_q[$];

   var_unshift_if bus ();

   var_unshift dut (
      .clk   (clk),
      .clr   (clr),
      .dir   (dir),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_push(input logic [31:0] word);
      bus.in_data  = word;
      bus.in_valid = 1'b1;
      #1;
      check("in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic do_pop(input int len, input logic [31:0] exp);
      exp_q.push_back(exp);
      bus.req_len   = 6'(len);
      bus.req_valid = 1'b1;
      #1;
      check("req_ready", 64'(bus.req_ready), 64'd1);
      tick();
      bus.req_valid = 1'b0;
      check("q_valid", 64'(bus.q_valid), 64'd1);
      check("q", 64'(bus.q), 64'(exp_q.pop_front()));
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      dir           = 1'b0;
      flush         = 1'b0;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_len   = 6'd1;

      // reset
      clr = 1'b1;
      tick();
      clr = 1'b0;
      #1;
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_q", 64'(bus.q), 64'd0);
      check("rst_q_valid", 64'(bus.q_valid), 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);

      // LSB-first
      do_push(32'hDEADBEEF);
      check("lsb_count0", 64'(bus.count), 64'd32);
      do_pop(4, 32'hF);
      check("lsb_count1", 64'(bus.count), 64'd28);
      do_pop(8, 32'hEE);
      check("lsb_count2", 64'(bus.count), 64'd20);
      do_pop(20, 32'hDEADB);
      check("lsb_count3", 64'(bus.count), 64'd0);

      // MSB-first
      dir = 1'b1;
      tick();
      do_push(32'hDEADBEEF);
      do_pop(4, 32'hD);
      do_pop(12, 32'hEAD);
      do_pop(16, 32'hBEEF);
      check("msb_count", 64'(bus.count), 64'd0);

      // word straddle, LSB-first
      dir = 1'b0;
      tick();
      do_push(32'hF0000000);
      do_push(32'h0000000F);
      check("full_count", 64'(bus.count), 64'd64);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      check("full_occ", 64'(bus.occ), 64'd3);
      do_pop(28, 32'h0);
      do_pop(8, 32'hFF);
      check("strad_count", 64'(bus.count), 64'd28);
      do_pop(28, 32'h0);

      // backpressure: push while full is refused
      do_push(32'h11111111);
      do_push(32'h22222222);
      bus.in_data  = 32'h33333333;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("bp_count", 64'(bus.count), 64'd64);
      do_pop(32, 32'h11111111);
      check("bp_in_ready", 64'(bus.in_ready), 64'd1);
      do_pop(32, 32'h22222222);

      // concurrency
      do_push(32'hAAAA5555);
      do_push(32'h5A00C3C3);
      do_pop(24, 32'hAA5555);
      check("cc_count40", 64'(bus.count), 64'd40);
      check("cc_occ_high", 64'(bus.occ), 64'd2);
      bus.in_data  = 32'h12345678;
      bus.in_valid = 1'b1;
      #1;
      check("cc_in_ready40", 64'(bus.in_ready), 64'd0);
      do_pop(16, 32'hC3AA);
      check("cc_count24", 64'(bus.count), 64'd24);
      do_pop(16, 32'h00C3);
      bus.in_valid = 1'b0;
      check("cc_count40b", 64'(bus.count), 64'd40);
      do_pop(8, 32'h5A);
      do_pop(32, 32'h12345678);
      check("cc_count0", 64'(bus.count), 64'd0);

      // stall on empty
      bus.req_len   = 6'd1;
      bus.req_valid = 1'b1;
      #1;
      check("empty_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
      bus.req_valid = 1'b0;
      check("empty_q_valid", 64'(bus.q_valid), 64'd0);
      check("empty_count", 64'(bus.count), 64'd0);

      // illegal lengths
      do_push(32'hCAFEF00D);
      do_pop(8, 32'h0D);
      bus.req_len   = 6'd0;
      bus.req_valid = 1'b1;
      #1;
      check("len0_req_ready", 64'(bus.req_ready), 64'd1);
      tick();
      bus.req_valid = 1'b0;
      check("len0_err", 64'(bus.err), 64'd1);
      check("len0_q", 64'(bus.q), 64'd0);
      check("len0_q_valid", 64'(bus.q_valid), 64'd0);
      check("len0_count", 64'(bus.count), 64'd24);
      tick();
      check("err_pulse", 64'(bus.err), 64'd0);
      bus.req_len   = 6'd33;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      check("len33_err", 64'(bus.err), 64'd1);
      check("len33_count", 64'(bus.count), 64'd24);

      // len > count stalls even with a push in the same cycle
      bus.req_len   = 6'd28;
      bus.req_valid = 1'b1;
      bus.in_data   = 32'h01020304;
      bus.in_valid  = 1'b1;
      #1;
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
      tick();
      bus.req_valid = 1'b0;
      bus.in_valid  = 1'b0;
      check("stall_q_valid", 64'(bus.q_valid), 64'd0);
      check("stall_count", 64'(bus.count), 64'd56);
      do_pop(28, 32'h4CAFEF0);
      do_pop(28, 32'h0102030);
      check("drain_count", 64'(bus.count), 64'd0);

      // reset mid-stream with a request pending
      do_push(32'h11223344);
      do_push(32'h55667788);
      do_pop(16, 32'h3344);
      check("pre_clr_count", 64'(bus.count), 64'd48);
      clr           = 1'b1;
      bus.req_len   = 6'd8;
      bus.req_valid = 1'b1;
      tick();
      clr           = 1'b0;
      bus.req_valid = 1'b0;
      check("clr_count", 64'(bus.count), 64'd0);
      check("clr_q", 64'(bus.q), 64'd0);
      check("clr_q_valid", 64'(bus.q_valid), 64'd0);
      check("clr_in_ready", 64'(bus.in_ready), 64'd1);

      // flush drops a concurrent pop and keeps q
      do_push(32'h0F0F0F0F);
      do_pop(8, 32'h0F);
      flush         = 1'b1;
      bus.req_len   = 6'd8;
      bus.req_valid = 1'b1;
      tick();
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      check("flush_count", 64'(bus.count), 64'd0);
      check("flush_q_valid", 64'(bus.q_valid), 64'd0);
      check("flush_err", 64'(bus.err), 64'd0);
      check("flush_q", 64'(bus.q), 64'h0F);

      // dir change while data is held waits for the buffer to drain
      do_push(32'h87654321);
      do_pop(24, 32'h654321);
      check("dir_count8", 64'(bus.count), 64'd8);
      dir = 1'b1;
      tick();
      do_push(32'hA5A5A5A5);
      do_pop(8, 32'h87);
      do_pop(4, 32'h5);
      do_pop(28, 32'hA5A5A5A);
      tick();
      do_push(32'h80000001);
      do_pop(1, 32'h1);
      do_pop(31, 32'h1);
      check("dir_end_count", 64'(bus.count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
